// File: rtl/ram_bus_pkg.sv
// Shared types and defaults for the nibble-wide RAM bus master.
package ram_bus_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 4;
  localparam int WR_PULSE_DEF = 1;
  localparam int RD_WAIT_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    R_WAIT   = 3'd5,
    R_DONE   = 3'd6
  } state_e;

  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with zero flag; sizes strobe and read-wait phases.
module wait_counter
  import ram_bus_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Single-access master for a level-sensitive nibble RAM with
// glitch-free cs/we sequencing and a turnaround cycle before reads.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int RD_WAIT  = RD_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int CW = cnt_w(WR_PULSE, RD_WAIT);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_cs;
  logic              r_we;
  logic              r_rsp;
  logic              w_accept;
  logic              w_drive;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic [CW-1:0]     w_load_val;

  assign req_ready = (r_state == IDLE) & reset;
  assign w_accept  = req_valid & req_ready;

  // Bus is owned for the whole write, including setup and hold.
  assign w_drive  = (r_state == W_SETUP) |
                    (r_state == W_STROBE) |
                    (r_state == W_HOLD);
  assign ram_data = w_drive ? r_wdata : {DATA_W{1'bz}};

  wait_counter #(
    .W(CW)
  ) u_cnt (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = req_we ? W_SETUP : R_SETUP;
      end
      W_SETUP: begin
        w_next     = W_STROBE;
        w_load     = 1'b1;
        w_load_val = CW'(WR_PULSE - 1);
      end
      W_STROBE: begin
        w_dec = 1'b1;
        if (w_zero) w_next = W_HOLD;
      end
      W_HOLD: w_next = IDLE;
      R_SETUP: begin
        w_next     = R_WAIT;
        w_load     = 1'b1;
        w_load_val = CW'(RD_WAIT - 1);
      end
      R_WAIT: begin
        w_dec = 1'b1;
        if (w_zero) w_next = R_DONE;
      end
      R_DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_rsp   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cs    <= (w_next == W_STROBE) | (w_next == R_WAIT);
      r_we    <= (w_next == W_STROBE);
      r_rsp   <= (w_next == W_HOLD) | (w_next == R_DONE);
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == R_WAIT) && w_zero) r_rdata <= ram_data;
    end
  end

  assign ram_addr  = r_addr;
  assign ram_cs    = r_cs;
  assign ram_we    = r_we;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator-side controller for the 4-bit data RAM (12-bit address, cs, we, bidirectional 4-bit data bus).
- Accepts single read or write requests from the CPU core over a valid/ready handshake.
- Sequences address setup, the chip-select/write strobes and bus turnaround so the level-sensitive RAM never sees a glitched write or bus contention.
- Returns read data and a completion pulse to the core.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 4, RAM data width (nibble).
- WR_PULSE, 1, number of cycles cs and we are both high during a write; must be >= 1.
- RD_WAIT, 1, number of cycles cs is high before read data is sampled; must be >= 1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse (reads and writes).
- rsp_rdata  out  DATA_W  last read data, held until the next read completes.
- ram_addr  out  ADDR_W  RAM address.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_data  inout  DATA_W  RAM data bus; driven only in write states, else high-Z.

Behaviour:
- Reset values (reset low, asynchronous): state IDLE, ram_cs=0, ram_we=0, ram_data released (Z), ram_addr=0, rsp_valid=0, rsp_rdata=0, req_ready=0, wait counter 0.
- Reset mid-operation aborts the transfer immediately. No response is produced. The RAM may hold partial write data; this is accepted.
- req_ready = (state==IDLE) & reset. It is a combinational output.
- Accept occurs on the rising edge where req_valid & req_ready. req_we, req_addr and req_wdata are latched on that edge and ignored at all other times.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_DONE.
- IDLE: cs=0, we=0, bus Z, ram_addr holds its last value. On accept, go to W_SETUP if req_we=1, else R_SETUP.
- W_SETUP (1 cycle): ram_addr=latched addr, data driven, cs=0, we=0. Go to W_STROBE and load the counter with WR_PULSE-1.
- W_STROBE (WR_PULSE cycles): cs=1, we=1, addr and data stable. Decrement the counter. Leave for W_HOLD when the counter is 0.
- W_HOLD (1 cycle): cs=0, we=0, data still driven, addr held, rsp_valid=1. Go to IDLE.
- R_SETUP (1 cycle, bus turnaround): ram_addr=latched addr, bus Z, cs=0, we=0. Go to R_WAIT and load the counter with RD_WAIT-1.
- R_WAIT (RD_WAIT cycles): cs=1, we=0, bus Z. On the edge leaving the final R_WAIT cycle, capture ram_data into rsp_rdata.
- R_DONE (1 cycle): cs=0, rsp_valid=1, rsp_rdata valid. Go to IDLE.
- Invariants:
  - Never drive ram_data while cs=1 & we=0.
  - we is never high while cs is low.
  - ram_addr and ram_data never change while we=1.
- Latency from the accept edge T:
  - Write: rsp_valid high in cycle T+2+WR_PULSE.
  - Read: rsp_valid high in cycle T+2+RD_WAIT.
  - Minimum spacing between accepts: write 3+WR_PULSE cycles, read 3+RD_WAIT cycles.
- Address range: full 0..4095. No wrap or increment logic; single accesses only.
- rsp_rdata is unchanged by writes.
- All outputs except req_ready and the ram_data tri-state enable are registered. Both of those decode from state.

Decomposition:
- Shared package ram_bus_pkg: state enum (3-bit encoding, IDLE=0), ADDR_W/DATA_W defaults, WR_PULSE/RD_WAIT defaults.
- One sub-module, wait_counter: loadable down-counter with a zero flag, async active-low reset, width = clog2(max(WR_PULSE,RD_WAIT))+1.
- The tri-state driver reuses the existing 4-bit tri-state buffer, with enable = write states.

Test Plan:
- Reset held low mid-W_STROBE (addr 0x123, data 0xA) -> cs/we drop to 0 and the bus goes Z in the same cycle. After release, req_ready=1 and no rsp_valid.
- Write 0x7 to 0xFFF, WR_PULSE=1 -> cs&we high exactly 1 cycle, addr=0xFFF and data=0x7 stable one cycle before and after. rsp_valid at T+3. A read-back from 0xFFF returns rsp_rdata=0x7 at T'+3.
- Read from an unwritten address 0x000 after a preload of 0x5 -> rsp_rdata=0x5. Bus Z throughout. Contention checker (cs&~we & drive) never fires.
- WR_PULSE=3, RD_WAIT=2: write 0xC to 0x800, then read it -> strobe 3 cycles, write rsp at T+5, read rsp at T+4 after its accept, rdata=0xC.
- req_valid held high with changing addr/data during a busy write -> only the accept-edge values are used. req_ready stays 0 until IDLE. The second request is accepted the cycle after rsp_valid.
- Alternating back-to-back write/read to 0x3A5 with data 0x0, 0xF, 0x9 -> each read returns the preceding write. rsp_valid pulses exactly once per request. rsp_rdata is unchanged across the writes.
